sevenseg_encoder: RTL and testbench

SEVENSEG_ENCODER -- requirements
Module: sevenseg_encoder

---
 rtl/sevenseg_encoder_pkg.sv | 28 ++
 rtl/sevenseg_encoder_seg_to_digit.sv | 37 +++
 rtl/sevenseg_encoder.sv | 147 ++++++++++++++
 tb/tb_sevenseg_encoder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_encoder_pkg.sv
// ---------------------------------------------------------------------------
// sevenseg_encoder_pkg
//   Shared definitions for the seven-segment encoder and the existing
//   binary-to-7seg decoder: FSM state enum and the ten active-low digit
//   patterns.
//   Pattern bit order: bit0=top, 1=upper-right, 2=lower-right, 3=bottom,
//   4=lower-left, 5=upper-left, 6=middle. A 0 bit means the segment is lit.
// ---------------------------------------------------------------------------
package sevenseg_encoder_pkg;

  typedef enum logic [1:0] {
    S_ONES = 2'd0,
    S_TENS = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000011;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0011000;

endpackage

// File: rtl/sevenseg_encoder_seg_to_digit.sv
// ---------------------------------------------------------------------------
// seg_to_digit
//   Combinational exact-match decode of an active-low 7-segment pattern to a
//   BCD digit. Anything that is not one of the ten legal patterns yields
//   digit 0 with err set.
// Ports:
//   pattern  in   7  active-low segment pattern
//   digit    out  4  decoded digit 0..9
//   err      out  1  pattern was not a legal digit
// ---------------------------------------------------------------------------
module seg_to_digit
  import sevenseg_encoder_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       err
);

  always_comb begin
    digit = 4'd0;
    err   = 1'b0;
    unique case (pattern)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/sevenseg_encoder.sv
// ---------------------------------------------------------------------------
// sevenseg_encoder
//   Accepts two 7-segment digit symbols (ones then tens, tagged by seg_pos),
//   and produces the binary value tens*10+ones plus a 4-bit switch code,
//   range / pattern error flags and a saturating error counter.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   seg_in[6:0]         active-low segment pattern
//   seg_pos             0=ones digit, 1=tens digit
//   in_valid/in_ready   input handshake
//   value[6:0]          result 0..99
//   sw_out[3:0]         value[3:0] when value<=15, else 0
//   range_err           value>15
//   pat_err             either digit pattern was illegal
//   out_valid/out_ready output handshake
//   err_count           saturating count of bad frames and sync drops
// ---------------------------------------------------------------------------
module sevenseg_encoder
  import sevenseg_encoder_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           seg_in,
  input  logic                 seg_pos,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [6:0]           value,
  output logic [3:0]           sw_out,
  output logic                 range_err,
  output logic                 pat_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ERR_CNT_W-1:0] err_count
);

  state_t               state_reg;
  state_t               state_next;
  logic                 ready_en_reg;
  logic [3:0]           ones_digit_reg;
  logic                 ones_err_reg;
  logic [6:0]           value_reg;
  logic [3:0]           sw_reg;
  logic                 range_reg;
  logic                 pat_reg;
  logic [ERR_CNT_W-1:0] err_count_reg;

  logic [3:0] dec_digit;
  logic       dec_err;
  logic       accept;
  logic       ones_load;
  logic       tens_load;
  logic       sync_drop;
  logic       frame_err;
  logic       err_inc;
  logic [6:0] tens_ext;
  logic [6:0] frame_value;
  logic       frame_range;

  // Single decoder shared between the ones and tens symbols: only one
  // symbol can be accepted per cycle.
  seg_to_digit u_seg_to_digit (
    .pattern (seg_in),
    .digit   (dec_digit),
    .err     (dec_err)
  );

  assign accept    = in_valid & in_ready;
  // A seg_pos=0 symbol always (re)loads the ones digit, whether it starts a
  // frame or resynchronises one. in_ready is low in S_OUT so no load there.
  assign ones_load = accept & ~seg_pos;
  assign tens_load = accept & seg_pos & (state_reg == S_TENS);
  // Tens without a ones, or a second ones before the tens.
  assign sync_drop = accept & (((state_reg == S_ONES) & seg_pos) |
                               ((state_reg == S_TENS) & ~seg_pos));
  assign frame_err = dec_err | ones_err_reg;
  assign err_inc   = sync_drop | (tens_load & frame_err);

  // tens*10 as (tens<<3)+(tens<<1); max 99 so 7 bits never overflow.
  assign tens_ext    = {3'b000, dec_digit};
  assign frame_value = (tens_ext << 3) + (tens_ext << 1) + {3'b000, ones_digit_reg};
  assign frame_range = (frame_value > 7'd15);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_ONES;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_ONES:  if (accept && !seg_pos) state_next = S_TENS;
      S_TENS:  if (accept && seg_pos)  state_next = S_OUT;
      S_OUT:   if (out_ready)          state_next = S_ONES;
      default: state_next = S_ONES;
    endcase
  end

  // Output logic: in_ready is held off until the first clock after reset
  // deassertion.
  always_comb begin
    in_ready  = ready_en_reg & (state_reg != S_OUT);
    out_valid = (state_reg == S_OUT);
  end

  // Datapath: captured ones digit, result registers, error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_reg   <= 1'b0;
      ones_digit_reg <= 4'd0;
      ones_err_reg   <= 1'b0;
      value_reg      <= 7'd0;
      sw_reg         <= 4'd0;
      range_reg      <= 1'b0;
      pat_reg        <= 1'b0;
      err_count_reg  <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      if (ones_load) begin
        ones_digit_reg <= dec_digit;
        ones_err_reg   <= dec_err;
      end
      if (tens_load) begin
        value_reg <= frame_value;
        sw_reg    <= frame_range ? 4'd0 : frame_value[3:0];
        range_reg <= frame_range;
        pat_reg   <= frame_err;
      end
      if (err_inc && (err_count_reg != {ERR_CNT_W{1'b1}})) begin
        err_count_reg <= err_count_reg + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign value     = value_reg;
  assign sw_out    = sw_reg;
  assign range_err = range_reg;
  assign pat_err   = pat_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_sevenseg_encoder.sv
// ---------------------------------------------------------------------------
// tb_sevenseg_encoder
//   Self-checking bench: a table of complete frames, hand-written sequences
//   for handshake / resync / saturation / reset corner cases, and a random
//   phase checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_sevenseg_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       seg_pos;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] value;
  logic [3:0] sw_out;
  logic       range_err;
  logic       pat_err;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] err_count;

  sevenseg_encoder #(.ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .seg_pos   (seg_pos),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .value     (value),
    .sw_out    (sw_out),
    .range_err (range_err),
    .pat_err   (pat_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_prints = 0;
  int exp_err = 0;

  // Legal digit patterns written out independently of the design package.
  logic [6:0] seg_tbl [10];
  logic [6:0] bad_a;
  logic [6:0] bad_b;

  typedef struct {
    logic [6:0] ones;
    logic [6:0] tens;
    int         exp_value;
    int         exp_sw;
    int         exp_range;
    int         exp_pat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) begin
      pass_cnt++;
    end else if (fail_prints < 40) begin
      fail_prints++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int ref_digit(input logic [6:0] p, output bit bad);
    int d;
    d = 0;
    bad = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (p == seg_tbl[i]) begin
        d = i;
        bad = 1'b0;
      end
    end
    return d;
  endfunction

  function automatic void err_bump();
    if (exp_err < 255) exp_err++;
  endfunction

  // Entered and left at a negedge.
  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    seg_in    = 7'd0;
    seg_pos   = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_value", value, 0);
    check("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", in_ready, 0);
    @(negedge clk);
    check("ready_after_edge", in_ready, 1);
    exp_err = 0;
  endtask

  task automatic send(input logic [6:0] s, input logic p);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL in_ready_timeout: got 0, expected 1 (t=%0t)", $time);
    end
    seg_in   = s;
    seg_pos  = p;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic frame(input logic [6:0] o, input logic [6:0] t);
    send(o, 1'b0);
    send(t, 1'b1);
    check("out_valid_latency", out_valid, 1);
  endtask

  task automatic take_result(input int v, input int sw, input int rng, input int pat);
    $display("frame result value=%0d sw_out=%0h range_err=%0d pat_err=%0d err_count=%0d",
             value, sw_out, range_err, pat_err, err_count);
    check("value", value, v);
    check("sw_out", sw_out, sw);
    check("range_err", range_err, rng);
    check("pat_err", pat_err, pat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_release", out_valid, 0);
  endtask

  initial begin
    bit         pend, have_ones, b1, b2;
    int         o_d, m_val, d;
    bit         o_bad, m_pat;

    seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000011, 7'b1111000, 7'b0000000, 7'b0011000};
    bad_a = 7'b1111111;
    bad_b = 7'b1111110;

    vecs[0] = '{seg_tbl[4], seg_tbl[1], 14, 14, 0, 0};
    vecs[1] = '{seg_tbl[3], seg_tbl[8], 83, 0, 1, 0};
    vecs[2] = '{bad_a,      seg_tbl[0], 0,  0, 0, 1};
    vecs[3] = '{seg_tbl[7], seg_tbl[0], 7,  7, 0, 0};
    vecs[4] = '{seg_tbl[5], seg_tbl[1], 15, 15, 0, 0};
    vecs[5] = '{seg_tbl[6], seg_tbl[1], 16, 0, 1, 0};
    vecs[6] = '{seg_tbl[9], seg_tbl[9], 99, 0, 1, 0};
    vecs[7] = '{seg_tbl[2], bad_b,      2,  2, 0, 1};
    vecs[8] = '{seg_tbl[0], seg_tbl[0], 0,  0, 0, 0};

    in_valid  = 1'b0;
    out_ready = 1'b0;
    seg_in    = 7'd0;
    seg_pos   = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);

    // Table of complete frames from a fresh reset
    do_reset();
    for (int i = 0; i < 9; i++) begin
      frame(vecs[i].ones, vecs[i].tens);
      if (vecs[i].exp_pat != 0) err_bump();
      check("err_count_table", err_count, exp_err);
      take_result(vecs[i].exp_value, vecs[i].exp_sw, vecs[i].exp_range, vecs[i].exp_pat);
    end

    // Output held with out_ready low while in_valid stays high
    do_reset();
    frame(seg_tbl[3], seg_tbl[8]);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      seg_pos  = 1'b1;
      seg_in   = seg_tbl[1];
      @(negedge clk);
      check("hold_value", value, 83);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    check("hold_no_consume", err_count, 0);
    take_result(83, 0, 1, 0);

    // Illegal ones pattern counts one error
    do_reset();
    frame(bad_a, seg_tbl[0]);
    check("illegal_err_count", err_count, 1);
    take_result(0, 0, 0, 1);

    // Tens first (drop), then ones, resync ones, tens
    do_reset();
    send(seg_tbl[5], 1'b1);
    check("drop_err_count", err_count, 1);
    send(seg_tbl[5], 1'b0);
    send(seg_tbl[7], 1'b0);
    check("resync_err_count", err_count, 2);
    send(seg_tbl[2], 1'b1);
    check("resync_out_valid", out_valid, 1);
    take_result(27, 0, 1, 0);
    check("resync_final_err", err_count, 2);

    // Saturation
    do_reset();
    for (int i = 0; i < 255; i++) send(seg_tbl[1], 1'b1);
    check("sat_reach", err_count, 255);
    frame(bad_a, seg_tbl[0]);
    check("sat_hold", err_count, 255);
    take_result(0, 0, 0, 1);
    send(seg_tbl[1], 1'b1);
    check("sat_hold_drop", err_count, 255);

    // Reset in S_TENS and in S_OUT discards the frame
    do_reset();
    send(seg_tbl[3], 1'b0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", out_valid, 0);
    end
    frame(seg_tbl[1], seg_tbl[2]);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("out_rst_out_valid", out_valid, 0);
    check("out_rst_value", value, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("out_rst_stays_idle", out_valid, 0);
    frame(seg_tbl[9], seg_tbl[9]);
    take_result(99, 0, 1, 0);
    check("out_rst_err", err_count, 0);

    // Random traffic against a transaction-level model
    do_reset();
    pend = 1'b0;
    have_ones = 1'b0;
    o_d = 0;
    o_bad = 1'b0;
    m_val = 0;
    m_pat = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      check("rnd_in_ready", in_ready, pend ? 0 : 1);
      check("rnd_out_valid", out_valid, pend ? 1 : 0);
      check("rnd_err_count", err_count, exp_err);
      if (pend) begin
        check("rnd_value", value, m_val);
        check("rnd_sw_out", sw_out, (m_val <= 15) ? m_val : 0);
        check("rnd_range_err", range_err, (m_val > 15) ? 1 : 0);
        check("rnd_pat_err", pat_err, m_pat ? 1 : 0);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      seg_pos   = 1'($urandom_range(0, 1));
      seg_in    = ($urandom_range(0, 7) == 0) ? 7'($urandom) : seg_tbl[$urandom_range(0, 9)];
      out_ready = 1'($urandom_range(0, 1));
      if (pend) begin
        if (out_ready) begin
          pend = 1'b0;
          have_ones = 1'b0;
        end
      end else if (in_valid) begin
        d = ref_digit(seg_in, b1);
        if (!seg_pos) begin
          if (have_ones) err_bump();
          have_ones = 1'b1;
          o_d = d;
          o_bad = b1;
        end else if (!have_ones) begin
          err_bump();
        end else begin
          b2 = b1;
          m_val = d * 10 + o_d;
          m_pat = b2 | o_bad;
          if (m_pat) err_bump();
          pend = 1'b1;
          $display("rnd frame ones=%0d tens=%0d expect value=%0d pat_err=%0d", o_d, d, m_val, m_pat);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
